// File: rtl/sr_pkg.sv
// Shared definitions for the serial-link receive path.
//   sr_rx_state_t : receiver FSM states (IDLE between frames, SHIFT mid-frame)
//   SR_WIDTH_DEF  : default word length in bits
package sr_pkg;

  typedef enum logic {IDLE, SHIFT} sr_rx_state_t;

  localparam int unsigned SR_WIDTH_DEF = 4;

endpackage

// File: rtl/sr_shift_in.sv
// Shift-in register for the LSB-first serial word.
// Each enabled cycle the new bit enters at the MSB and the register moves right.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift this cycle
//   din        : incoming serial bit
//   word       : {din, shift[WIDTH-1:1]}, the word as it becomes after the next shift;
//                once the last bit is on din this is the complete word in natural order
module sr_shift_in import sr_pkg::*; #(
  parameter int unsigned WIDTH = SR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  // Bit 0 of the full shift register is shifted out on the very next shift without ever
  // being read, so only the upper WIDTH-1 bits are kept.
  logic [WIDTH-2:0] shift_q;

  assign word = {din, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (en) begin
      shift_q <= word[WIDTH-1:1];
    end
  end

endmodule

// File: rtl/sr_deserializer.sv
// Receive end of the parallel-load / shift-right serial link.
// Reassembles LSB-first words framed by sof and presents them on a valid/ready port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   sdi, sdi_valid, sof  : serial bit, bit strobe, start-of-frame (qualified by sdi_valid)
//   out_data, out_valid  : completed word, held until accepted
//   out_ready            : consumer accept
//   busy                 : mid-frame
//   frame_err            : one-cycle pulse when a frame is aborted by a new sof
//   overrun              : sticky, a completed word was dropped; cleared by clr_ovr
//   clr_ovr              : synchronous overrun clear, wins over a same-cycle set
module sr_deserializer import sr_pkg::*; #(
  parameter int unsigned WIDTH = SR_WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  sr_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             shift_en;
  logic             complete;
  logic             load;
  logic [WIDTH-1:0] word;

  sr_shift_in #(
    .WIDTH (WIDTH)
  ) u_shift_in (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .din   (sdi),
    .word  (word)
  );

  // Frame FSM and bit counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_en    = 1'b0;
    complete    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Bits without sof between frames are ignored.
        if (sdi_valid && sof) begin
          shift_en = 1'b1;
          cnt_d    = CntOne;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sdi_valid) begin
          shift_en = 1'b1;
          if (sof) begin
            // Abort and restart with this bit as bit 0.
            frame_err_d = 1'b1;
            cnt_d       = CntOne;
          end else if (cnt_q == CntLast) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
    endcase
  end

  // Output register and flags
  always_comb begin
    // A completed word is taken if the output slot is empty or being emptied this cycle.
    load        = complete && (!out_valid_q || out_ready);
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d  = load ? word : out_data_q;
    overrun_d   = clr_ovr ? 1'b0 : (overrun_q || (complete && out_valid_q && !out_ready));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == SHIFT);

endmodule
